pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised inter-stage pipeline register for the 16-bit RISC core. It is the successor to the fixed-width, always-load stage registers (IF/ID, ID/RR, RR/EX, EX/MEM, MEM/WB). It carries a control field and a data payload with a valid/ready handshake and a 2-entry skid buffer, so stalls propagate without a combinational ready path. It also supports flush with bubble insertion and a saturating stall counter for performance debug. One instance sits between each pair of pipeline stages.

## Interface
Parameters:
- CTRL_W, 15, width of control field (WB/M/EX bits); zeroed whenever the stage holds a bubble
- DATA_W, 128, width of payload (operands, immediates, PC, PC+1, instruction, register indices)
- BUBBLE_ZERO, 1, 1: out_data forced to 0 when out_valid=0; 0: out_data holds the last main-entry contents
- CNT_W, 16, stall counter width

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat
- in_ctrl  in  CTRL_W  upstream control field
- in_data  in  DATA_W  upstream payload
- flush  in  1  kill all held beats (branch/jump redirect)
- out_valid  out  1  beat presented downstream
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  control field; 0 when out_valid=0
- out_data  out  DATA_W  payload (see BUBBLE_ZERO)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- stall_clr  in  1  synchronous clear of stall_cnt

## Operation
- Storage: main entry M (drives outputs) and skid entry S, each with a valid bit, ctrl and data.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_valid = M.valid.
  - in_ready = !S.valid, decoded from registered state only.
- State machine, with flush not asserted:
  - EMPTY (M and S invalid): in_fire loads M and goes to ONE.
  - ONE (M valid, S invalid):
    - in_fire & out_fire: M<=in, stay in ONE.
    - in_fire & !out_ready: S<=in, go to FULL.
    - out_fire & !in_fire: go to EMPTY.
    - no fire: hold.
  - FULL (both valid, in_ready=0): out_fire moves M<=S and goes to ONE; otherwise hold.
- Flush has highest priority:
  - Next state is EMPTY and both valid bits clear.
  - A beat offered in the flush cycle completes its handshake if in_ready=1 and is discarded.
  - out_fire in the flush cycle still counts downstream; the flush kills only held beats after that edge.
- Ordering is strictly FIFO. No beat is duplicated or dropped except by flush.
- Bubble masking:
  - out_ctrl = M.valid ? M.ctrl : 0.
  - out_data = (M.valid | !BUBBLE_ZERO) ? M.data : 0.
- Stall counter:
  - +1 per cycle with out_valid & !out_ready, saturating at 2^CNT_W-1.
  - stall_clr takes priority over increment (result 0).
  - flush does not affect the counter.
- Reset (reset_n low, asynchronous):
  - State goes to EMPTY and all entries are zeroed.
  - Outputs: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=1.
  - Inputs are ignored while reset_n is low.
  - Reset mid-operation discards both held beats immediately and does not wait for a clock edge.

## Timing
- Latency: a beat accepted at edge N appears on out_* after edge N (1 cycle) when the stage was EMPTY or ONE with out_fire.
- Throughput: 1 beat/cycle sustained with out_ready=1.
- in_ready has no combinational dependence on out_ready, in_valid or flush.
  - in_ready falls the cycle after FULL is entered.
  - in_ready rises the cycle after the out_fire that leaves FULL.
- Combinational paths to outputs: only the valid-masking AND gates on out_ctrl/out_data.
- flush takes effect at the next posedge. out_valid=0 in the cycle following flush.
- Release of reset_n must be synchronised externally to clock.

## Test plan
- Reset: drive reset_n=0 mid-stream with both entries full -> out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=1 immediately, without a clock edge.
- Streaming: 8 beats data=0x1..0x8, ctrl=0x7FFF, out_ready=1 -> outputs 0x1..0x8 in order, each 1 cycle after acceptance, in_ready constantly 1.
- Backpressure: beats A, B, C offered back-to-back, out_ready=0 from cycle 1 -> A held on out, B in skid, in_ready=0 from cycle 2, C not accepted. Raise out_ready for 3 cycles -> A, B, C emerge in order. stall_cnt equals the number of stalled cycles.
- Flush: stage FULL, assert flush for 1 cycle -> next cycle out_valid=0, out_ctrl=0, out_data=0 (BUBBLE_ZERO=1), in_ready=1. The beat offered in the flush cycle never appears downstream.
- Bubble hold: BUBBLE_ZERO=0, beat 0xABCD accepted then drained -> out_valid=0, out_ctrl=0, out_data stays 0xABCD.
- Counter: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15. stall_clr together with a stall cycle -> stall_cnt=0, then increments to 1 on the next stalled cycle.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// in_ready is decoded from registered state only, so downstream stalls never form a combinational ready chain.
module pipe_stage_skid #(
    parameter int unsigned CTRL_W      = 15,
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned BUBBLE_ZERO = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              in_fire;
    logic              out_fire;

    assign m_valid   = (state != EMPTY);
    assign out_valid = m_valid;
    assign in_ready  = (state != FULL);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Bubble masking is the only combinational logic on the output side.
    assign out_ctrl = m_valid ? m_ctrl : '0;
    assign out_data = (m_valid || (BUBBLE_ZERO == 0)) ? m_data : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            m_ctrl    <= '0;
            m_data    <= '0;
            s_ctrl    <= '0;
            s_data    <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall_clr) begin
                stall_cnt <= '0;
            end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            // Flush only drops the valid state; entry contents stay for BUBBLE_ZERO=0 hold.
            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (in_fire) begin
                            m_ctrl <= in_ctrl;
                            m_data <= in_data;
                            state  <= ONE;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            m_ctrl <= in_ctrl;
                            m_data <= in_data;
                        end else if (in_fire) begin
                            s_ctrl <= in_ctrl;
                            s_data <= in_data;
                            state  <= FULL;
                        end else if (out_fire) begin
                            state <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_fire) begin
                            m_ctrl <= s_ctrl;
                            m_data <= s_data;
                            state  <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: scoreboard on the default instance, directed checks on a
// second instance configured with BUBBLE_ZERO=0 and a 4-bit stall counter.
module tb_pipe_stage_skid;

    localparam int unsigned CW = 15;
    localparam int unsigned DW = 128;
    localparam int unsigned BCW = 8;
    localparam int unsigned BDW = 16;

    typedef logic [CW+DW-1:0] beat_t;

    logic          clock;
    logic          reset_n;
    logic          in_valid, in_ready, flush, out_valid, out_ready, stall_clr;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [15:0]   stall_cnt;

    logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall_clr;
    logic [BCW-1:0] b_in_ctrl, b_out_ctrl;
    logic [BDW-1:0] b_in_data, b_out_data;
    logic [3:0]     b_stall_cnt;

    int    total = 0;
    int    bad   = 0;
    beat_t exp_q[$];

    pipe_stage_skid u_dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .stall_cnt(stall_cnt),
        .stall_clr(stall_clr)
    );

    pipe_stage_skid #(.CTRL_W(BCW), .DATA_W(BDW), .BUBBLE_ZERO(0), .CNT_W(4)) u_hold (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_ctrl  (b_in_ctrl),
        .in_data  (b_in_data),
        .flush    (1'b0),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_ctrl (b_out_ctrl),
        .out_data (b_out_data),
        .stall_cnt(b_stall_cnt),
        .stall_clr(b_stall_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops one expected beat per downstream handshake; flush/reset drop held beats.
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_beat", {16'd0, out_ctrl, out_data}, 160'd0);
                else chk("sb_beat", {16'd0, out_ctrl, out_data}, {16'd0, exp_q.pop_front()});
            end
            if (flush) exp_q.delete();
        end
    end

    // One clock: record the accepted beat at the negedge, return 1 time unit after posedge.
    task automatic step();
        @(negedge clock);
        if (reset_n && in_valid && in_ready && !flush) exp_q.push_back({in_ctrl, in_data});
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0; stall_clr = 1'b0;
        b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0; b_out_ready = 1'b0; b_stall_clr = 1'b0;
        #3;
        chk("rst_out_valid", 160'(out_valid), 160'd0);
        chk("rst_in_ready", 160'(in_ready), 160'd1);
        chk("rst_out_data", 160'(out_data), 160'd0);
        chk("rst_stall_cnt", 160'(stall_cnt), 160'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Streaming: 1-cycle latency, full throughput, in_ready stays high.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            offer(15'h7FFF, DW'(i));
            step();
            chk("strm_valid", 160'(out_valid), 160'd1);
            chk("strm_data", 160'(out_data), 160'(i));
            chk("strm_in_ready", 160'(in_ready), 160'd1);
        end
        in_valid = 1'b0;
        step();
        chk("strm_drain_valid", 160'(out_valid), 160'd0);
        chk("strm_drain_ctrl", 160'(out_ctrl), 160'd0);
        chk("strm_drain_data", 160'(out_data), 160'd0);

        // Backpressure: A in main, B in skid, C refused until space frees.
        out_ready = 1'b0;
        offer(15'h0A, 128'hA);
        step();
        chk("bp_a_out", 160'(out_data), 160'hA);
        chk("bp_ready1", 160'(in_ready), 160'd1);
        offer(15'h0B, 128'hB);
        step();
        chk("bp_full_ready", 160'(in_ready), 160'd0);
        chk("bp_hold_a", 160'(out_data), 160'hA);
        offer(15'h0C, 128'hC);
        step();
        step();
        chk("bp_still_full", 160'(in_ready), 160'd0);
        chk("bp_still_a", 160'(out_data), 160'hA);
        chk("bp_stall_cnt", 160'(stall_cnt), 160'd3);
        out_ready = 1'b1;
        step();
        chk("bp_b_out", 160'(out_data), 160'hB);
        chk("bp_ready_back", 160'(in_ready), 160'd1);
        step();
        chk("bp_c_out", 160'(out_data), 160'hC);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 160'(out_valid), 160'd0);
        chk("bp_stall_final", 160'(stall_cnt), 160'd3);

        // Flush from FULL; then flush from ONE with an accepted-and-discarded beat.
        out_ready = 1'b0;
        offer(15'h0D, 128'hD);
        step();
        offer(15'h0E, 128'hE);
        step();
        offer(15'h0F, 128'hF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 160'(out_valid), 160'd0);
        chk("fl_ctrl", 160'(out_ctrl), 160'd0);
        chk("fl_data", 160'(out_data), 160'd0);
        chk("fl_ready", 160'(in_ready), 160'd1);
        offer(15'h10, 128'h10);
        step();
        offer(15'h11, 128'h11);
        out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl2_valid", 160'(out_valid), 160'd0);
        step();
        step();
        chk("fl2_no_ghost", 160'(out_valid), 160'd0);
        chk("fl_stall_cnt", 160'(stall_cnt), 160'd5);
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        chk("clr_main", 160'(stall_cnt), 160'd0);

        // Bubble hold (BUBBLE_ZERO=0) and 4-bit counter saturation.
        b_in_valid = 1'b1; b_in_ctrl = 8'h5A; b_in_data = 16'hABCD; b_out_ready = 1'b1;
        step();
        chk("hold_load", 160'(b_out_data), 160'hABCD);
        b_in_valid = 1'b0;
        step();
        chk("hold_valid", 160'(b_out_valid), 160'd0);
        chk("hold_ctrl", 160'(b_out_ctrl), 160'd0);
        chk("hold_data", 160'(b_out_data), 160'hABCD);
        b_in_valid = 1'b1; b_in_data = 16'h1234; b_out_ready = 1'b0;
        step();
        b_in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("cnt_sat", 160'(b_stall_cnt), 160'd15);
        b_stall_clr = 1'b1;
        step();
        b_stall_clr = 1'b0;
        chk("cnt_clr", 160'(b_stall_cnt), 160'd0);
        step();
        chk("cnt_after_clr", 160'(b_stall_cnt), 160'd1);

        // Asynchronous reset with the main stage FULL.
        out_ready = 1'b0;
        offer(15'h21, 128'h21);
        step();
        offer(15'h22, 128'h22);
        step();
        chk("pre_rst_full", 160'(in_ready), 160'd0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 160'(out_valid), 160'd0);
        chk("arst_ctrl", 160'(out_ctrl), 160'd0);
        chk("arst_data", 160'(out_data), 160'd0);
        chk("arst_cnt", 160'(stall_cnt), 160'd0);
        chk("arst_ready", 160'(in_ready), 160'd1);
        chk("arst_hold_data", 160'(b_out_data), 160'd0);
        chk("arst_hold_cnt", 160'(b_stall_cnt), 160'd0);
        offer(15'h33, 128'h33);
        step();
        step();
        chk("rst_ignores_in", 160'(out_valid), 160'd0);
        in_valid = 1'b0;
        reset_n = 1'b1;
        out_ready = 1'b1;
        offer(15'h44, 128'h44);
        step();
        chk("post_rst_beat", 160'(out_data), 160'h44);
        in_valid = 1'b0;
        step();
        chk("post_rst_empty", 160'(out_valid), 160'd0);
        chk("sb_drained", 160'(exp_q.size()), 160'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
